// File: rtl/m_ptw_dram_port_pkg.sv
// ---------------------------------------------------------------------------
// m_ptw_dram_port_pkg
// Shared definitions for the page-walker DRAM port:
//   - PW_* : walker state codes as driven by m_mmu on pw_state
//            (states 4 and 7 never generate DRAM traffic, so they need no name)
//   - port_state_t : port FSM states
//   - is_read_state() : true for the walker states that request a PTE read
// ---------------------------------------------------------------------------
package m_ptw_dram_port_pkg;

   localparam logic [2:0] PW_IDLE    = 3'd0;  // L1 PTE address presented
   localparam logic [2:0] PW_L1_RD   = 3'd1;  // L1 PTE read
   localparam logic [2:0] PW_L0_ADDR = 3'd2;  // L0 PTE address presented
   localparam logic [2:0] PW_L0_RD   = 3'd3;  // L0 PTE read
   localparam logic [2:0] PW_UPD_WR  = 3'd5;  // A/D-bit PTE write-back

   typedef enum logic [1:0] {
      PORT_IDLE,
      PORT_RD_REQ,
      PORT_RD_WAIT,
      PORT_WB_REQ
   } port_state_t;

   function automatic logic is_read_state(input logic [2:0] ps);
      return (ps == PW_L1_RD) || (ps == PW_L0_RD);
   endfunction

endpackage

// File: rtl/m_ptw_dram_port_wait_counter.sv
// ---------------------------------------------------------------------------
// m_ptw_dram_port_wait_counter
// Counts consecutive cycles in which a DRAM access is stalled and raises a
// sticky timeout flag when the count reaches WAIT_LIMIT (0 disables it).
// Ports:
//   CLK      in   clock
//   RST      in   synchronous reset, active-high (clears count and flag)
//   count_en in   1 = this cycle is a stalled cycle, 0 = restart the count
//   timeout  out  sticky timeout flag
// ---------------------------------------------------------------------------
module m_ptw_dram_port_wait_counter #(
   parameter int unsigned WAIT_LIMIT = 1023
) (
   input  logic CLK,
   input  logic RST,
   input  logic count_en,
   output logic timeout
);

   localparam int unsigned     CNT_W   = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(WAIT_LIMIT);
   localparam logic            ENABLED = (WAIT_LIMIT != 0);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;

   assign cnt_inc = cnt + CNT_W'(1);

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         if (!count_en)
            cnt <= '0;
         else if (cnt != LIMIT)
            cnt <= cnt_inc;   // saturate once the limit is reached
         // flag rises at the end of the WAIT_LIMIT-th stalled cycle
         if (ENABLED && count_en && (cnt_inc == LIMIT))
            timeout <= 1'b1;
      end
   end

endmodule

// File: rtl/m_ptw_dram_port.sv
// ---------------------------------------------------------------------------
// m_ptw_dram_port
// Memory-side port for the page walker. Turns m_mmu PTE strobes into
// single-beat DRAM read/write requests, returns PTE data with a busy flag,
// and buffers the A/D-bit PTE write-back so the walker never stalls on it.
// Ports:
//   CLK, RST      clock; synchronous active-high reset
//   pw_state      walker state from m_mmu
//   pte_addr      PTE address (valid in pw_state 0/2/5, qualified by pte_acs)
//   pte_acs       pte_addr valid qualifier
//   pte_we        PTE write-back request (pw_state 5 only)
//   pte_wdata     PTE write-back data
//   mmu_busy      high while a PTE access is outstanding or pending
//   mmu_odata     last PTE read data, held until the next read returns
//   dram_req      request strobe, held until dram_ack
//   dram_we       1 write / 0 read
//   dram_addr     word-aligned request address
//   dram_wdata    write data
//   dram_ack      request accepted (pulse)
//   dram_rvalid   read data valid (pulse, same cycle as ack or later)
//   dram_rdata    read data
//   err_timeout   sticky: a request stalled for WAIT_LIMIT cycles
// ---------------------------------------------------------------------------
module m_ptw_dram_port
   import m_ptw_dram_port_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned WAIT_LIMIT = 1023
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [2:0]        pw_state,
   input  logic [ADDR_W-1:0] pte_addr,
   input  logic              pte_acs,
   input  logic              pte_we,
   input  logic [DATA_W-1:0] pte_wdata,
   output logic              mmu_busy,
   output logic [DATA_W-1:0] mmu_odata,
   output logic              dram_req,
   output logic              dram_we,
   output logic [ADDR_W-1:0] dram_addr,
   output logic [DATA_W-1:0] dram_wdata,
   input  logic              dram_ack,
   input  logic              dram_rvalid,
   input  logic [DATA_W-1:0] dram_rdata,
   output logic              err_timeout
);

   port_state_t       state;
   port_state_t       state_next;
   logic [2:0]        prev_state;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              wb_valid;
   logic              rd_pend;
   logic              discard;
   logic              rd_edge;
   logic              rd_want;
   logic              wb_capture;
   logic              rd_capture;
   logic              wait_en;
   logic              addr_lsb_unused;

   // Addresses are stored word-aligned, so the byte-offset bits are dropped.
   assign addr_lsb_unused = ^pte_addr[1:0];

   assign rd_edge    = (pw_state != prev_state) && is_read_state(pw_state);
   assign rd_want    = rd_edge | rd_pend;
   assign wb_capture = (pw_state == PW_UPD_WR) && pte_we;
   assign rd_capture = dram_rvalid &&
                       (((state == PORT_RD_REQ) && dram_ack) || (state == PORT_RD_WAIT));

   // ---- FSM: state register ----
   always_ff @(posedge CLK) begin
      if (RST) state <= PORT_IDLE;
      else     state <= state_next;
   end

   // ---- FSM: next state ----
   // No new request leaves IDLE while stale pulses from a reset-aborted
   // access may still arrive; a read edge seen then is kept as pending.
   always_comb begin
      state_next = state;
      case (state)
         PORT_IDLE: begin
            if (!discard) begin
               if (wb_valid)     state_next = PORT_WB_REQ;   // write-back before read
               else if (rd_want) state_next = PORT_RD_REQ;
            end
         end
         PORT_RD_REQ: begin
            if (dram_ack) state_next = dram_rvalid ? PORT_IDLE : PORT_RD_WAIT;
         end
         PORT_RD_WAIT: begin
            if (dram_rvalid) state_next = PORT_IDLE;
         end
         PORT_WB_REQ: begin
            if (dram_ack) state_next = PORT_IDLE;
         end
         default: state_next = PORT_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   // mmu_busy includes the raw read edge so m_mmu sees busy in the very
   // cycle it enters a read state and never latches stale data.
   always_comb begin
      dram_req   = 1'b0;
      dram_we    = 1'b0;
      dram_addr  = '0;
      dram_wdata = '0;
      case (state)
         PORT_RD_REQ: begin
            dram_req  = 1'b1;
            dram_addr = rd_addr;
         end
         PORT_WB_REQ: begin
            dram_req   = 1'b1;
            dram_we    = 1'b1;
            dram_addr  = wb_addr;
            dram_wdata = wb_data;
         end
         default: ;
      endcase
      mmu_busy = (state != PORT_IDLE) | wb_valid | rd_want;
   end

   // ---- datapath / bookkeeping registers ----
   always_ff @(posedge CLK) begin
      if (RST) begin
         prev_state <= PW_IDLE;
         rd_addr    <= '0;
         wb_addr    <= '0;
         wb_data    <= '0;
         wb_valid   <= 1'b0;
         rd_pend    <= 1'b0;
         discard    <= 1'b1;
         mmu_odata  <= '0;
      end else begin
         prev_state <= pw_state;

         if (((pw_state == PW_IDLE) || (pw_state == PW_L0_ADDR)) && pte_acs)
            rd_addr <= {pte_addr[ADDR_W-1:2], 2'b00};

         if (wb_capture) begin
            wb_valid <= 1'b1;
            wb_addr  <= {pte_addr[ADDR_W-1:2], 2'b00};
            wb_data  <= pte_wdata;
         end else if ((state == PORT_WB_REQ) && dram_ack) begin
            wb_valid <= 1'b0;
         end

         // a read edge that cannot start this cycle is remembered
         if ((state == PORT_IDLE) && (state_next == PORT_RD_REQ))
            rd_pend <= 1'b0;
         else if (rd_edge)
            rd_pend <= 1'b1;

         if ((state == PORT_IDLE) && !dram_ack && !dram_rvalid)
            discard <= 1'b0;

         if (rd_capture)
            mmu_odata <= dram_rdata;
      end
   end

   // stalled = request not yet accepted, or read accepted but data not back
   assign wait_en = (dram_req && !dram_ack) || ((state == PORT_RD_WAIT) && !dram_rvalid);

   m_ptw_dram_port_wait_counter #(
      .WAIT_LIMIT(WAIT_LIMIT)
   ) u_wait_counter (
      .CLK      (CLK),
      .RST      (RST),
      .count_en (wait_en),
      .timeout  (err_timeout)
   );

endmodule

// File: tb/tb_m_ptw_dram_port.sv
// ---------------------------------------------------------------------------
// tb_m_ptw_dram_port
// Directed bench for m_ptw_dram_port (WAIT_LIMIT = 8): zero-wait L1/L0 walk,
// buffered write-back ahead of the next walk, slow DRAM, timeout, reset
// during a read with a late rvalid, and the TLB-hit path.
// ---------------------------------------------------------------------------
module tb_m_ptw_dram_port;

   logic        CLK = 1'b0;
   logic        RST;
   logic [2:0]  pw_state;
   logic [31:0] pte_addr;
   logic        pte_acs;
   logic        pte_we;
   logic [31:0] pte_wdata;
   logic        mmu_busy;
   logic [31:0] mmu_odata;
   logic        dram_req;
   logic        dram_we;
   logic [31:0] dram_addr;
   logic [31:0] dram_wdata;
   logic        dram_ack;
   logic        dram_rvalid;
   logic [31:0] dram_rdata;
   logic        err_timeout;

   int errors = 0;
   int checks = 0;

   m_ptw_dram_port #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .WAIT_LIMIT (8)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .pw_state    (pw_state),
      .pte_addr    (pte_addr),
      .pte_acs     (pte_acs),
      .pte_we      (pte_we),
      .pte_wdata   (pte_wdata),
      .mmu_busy    (mmu_busy),
      .mmu_odata   (mmu_odata),
      .dram_req    (dram_req),
      .dram_we     (dram_we),
      .dram_addr   (dram_addr),
      .dram_wdata  (dram_wdata),
      .dram_ack    (dram_ack),
      .dram_rvalid (dram_rvalid),
      .dram_rdata  (dram_rdata),
      .err_timeout (err_timeout)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Address phase, read edge, request with same-cycle ack, rvalid one cycle
   // later; mmu_busy must drop exactly three cycles after the edge.
   task automatic zw_read(input string tag, input logic [2:0] aps, input logic [2:0] rps,
                          input logic [31:0] addr, input logic [31:0] pte);
      pw_state = aps; pte_acs = 1'b1; pte_addr = addr; #1;
      chk1({tag, "/addr_busy"}, mmu_busy, 1'b0);
      step(); pw_state = rps; pte_acs = 1'b0; #1;
      chk1({tag, "/edge_busy"}, mmu_busy, 1'b1);
      chk1({tag, "/edge_req"}, dram_req, 1'b0);
      step(); #1;
      chk1({tag, "/req"}, dram_req, 1'b1);
      chk1({tag, "/we"}, dram_we, 1'b0);
      chkw({tag, "/addr"}, dram_addr, addr);
      dram_ack = 1'b1;
      step(); dram_ack = 1'b0; dram_rvalid = 1'b1; dram_rdata = pte; #1;
      chk1({tag, "/wait_busy"}, mmu_busy, 1'b1);
      chk1({tag, "/wait_req"}, dram_req, 1'b0);
      step(); dram_rvalid = 1'b0; #1;
      chk1({tag, "/done_busy"}, mmu_busy, 1'b0);
      chkw({tag, "/odata"}, mmu_odata, pte);
   endtask

   initial begin
      RST = 1'b1; pw_state = 3'd0; pte_addr = '0; pte_acs = 1'b0; pte_we = 1'b0;
      pte_wdata = '0; dram_ack = 1'b0; dram_rvalid = 1'b0; dram_rdata = '0;
      step(); step();
      RST = 1'b0; #1;
      chk1("rst/busy", mmu_busy, 1'b0);
      chkw("rst/odata", mmu_odata, 32'h0);
      chk1("rst/req", dram_req, 1'b0);
      chk1("rst/we", dram_we, 1'b0);
      chkw("rst/addr", dram_addr, 32'h0);
      chkw("rst/wdata", dram_wdata, 32'h0);
      chk1("rst/err", err_timeout, 1'b0);

      // L1 then L0 walk against zero-wait DRAM
      zw_read("l1", 3'd0, 3'd1, 32'h8000_1004, 32'h1111_0001);
      zw_read("l0", 3'd2, 3'd3, 32'h8000_2010, 32'h2000_0081);

      // A/D write-back, then the next walk's L1 read must wait behind it
      pw_state = 3'd5; pte_we = 1'b1; pte_addr = 32'h8000_2010; pte_wdata = 32'h2000_00CF; #1;
      chk1("wb/cap_busy", mmu_busy, 1'b0);
      chk1("wb/cap_req", dram_req, 1'b0);
      step(); pw_state = 3'd0; pte_we = 1'b0; pte_acs = 1'b1; pte_addr = 32'h8000_1004; #1;
      chk1("wb/buf_busy", mmu_busy, 1'b1);
      chk1("wb/buf_req", dram_req, 1'b0);
      step(); pw_state = 3'd1; pte_acs = 1'b0; #1;
      chk1("wb/req", dram_req, 1'b1);
      chk1("wb/we", dram_we, 1'b1);
      chkw("wb/addr", dram_addr, 32'h8000_2010);
      chkw("wb/wdata", dram_wdata, 32'h2000_00CF);
      chk1("wb/busy", mmu_busy, 1'b1);
      step(); #1;
      chk1("wb/hold_req", dram_req, 1'b1);
      chk1("wb/hold_we", dram_we, 1'b1);
      dram_ack = 1'b1;
      step(); dram_ack = 1'b0; #1;
      chk1("wb/gap_req", dram_req, 1'b0);
      chk1("wb/gap_busy", mmu_busy, 1'b1);
      step(); #1;
      chk1("wb/rd_req", dram_req, 1'b1);
      chk1("wb/rd_we", dram_we, 1'b0);
      chkw("wb/rd_addr", dram_addr, 32'h8000_1004);
      dram_ack = 1'b1;
      step(); dram_ack = 1'b0; dram_rvalid = 1'b1; dram_rdata = 32'h3333_0001; #1;
      chkw("wb/rd_odata_hold", mmu_odata, 32'h2000_0081);
      step(); dram_rvalid = 1'b0; #1;
      chk1("wb/rd_busy", mmu_busy, 1'b0);
      chkw("wb/rd_odata", mmu_odata, 32'h3333_0001);

      // Slow DRAM: ack on the 5th request cycle, rvalid 3 cycles later;
      // unaligned pte_addr must be presented word-aligned
      pw_state = 3'd0; pte_acs = 1'b1; pte_addr = 32'h8000_300E;
      step(); pw_state = 3'd1; pte_acs = 1'b0; #1;
      chk1("slow/edge_busy", mmu_busy, 1'b1);
      step(); #1;
      chk1("slow/req", dram_req, 1'b1);
      chkw("slow/addr", dram_addr, 32'h8000_300C);
      for (int i = 3; i <= 8; i++) begin
         step(); dram_ack = (i == 6); #1;
         chk1("slow/busy", mmu_busy, 1'b1);
         chkw("slow/odata", mmu_odata, 32'h3333_0001);
         chk1("slow/req_hold", dram_req, i <= 6);
      end
      step(); dram_ack = 1'b0; dram_rvalid = 1'b1; dram_rdata = 32'h4444_0001; #1;
      chk1("slow/last_busy", mmu_busy, 1'b1);
      chkw("slow/last_odata", mmu_odata, 32'h3333_0001);
      step(); dram_rvalid = 1'b0; #1;
      chk1("slow/done_busy", mmu_busy, 1'b0);
      chkw("slow/odata_new", mmu_odata, 32'h4444_0001);
      chk1("slow/no_err", err_timeout, 1'b0);

      // Timeout: never ack; flag rises after the 8th stalled cycle, no abort
      pw_state = 3'd0; pte_acs = 1'b1; pte_addr = 32'h8000_4000;
      step(); pw_state = 3'd1; pte_acs = 1'b0;
      step(); #1;
      chk1("to/req0", dram_req, 1'b1);
      chk1("to/err0", err_timeout, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         step(); #1;
         chk1("to/err", err_timeout, k >= 8);
         chk1("to/req", dram_req, 1'b1);
      end
      RST = 1'b1; pw_state = 3'd0;
      step(); RST = 1'b0; #1;
      chk1("to/rst_err", err_timeout, 1'b0);
      chk1("to/rst_req", dram_req, 1'b0);
      chk1("to/rst_busy", mmu_busy, 1'b0);

      // Reset while in RD_WAIT, then a late rvalid that must be ignored
      pte_acs = 1'b1; pte_addr = 32'h8000_5000;
      step(); pw_state = 3'd1; pte_acs = 1'b0;
      step(); #1;
      chk1("rr/req", dram_req, 1'b1);
      chkw("rr/addr", dram_addr, 32'h8000_5000);
      dram_ack = 1'b1;
      step(); dram_ack = 1'b0; #1;
      chk1("rr/wait_busy", mmu_busy, 1'b1);
      RST = 1'b1; pw_state = 3'd0;
      step(); RST = 1'b0; dram_rvalid = 1'b1; dram_rdata = 32'hDEAD_BEEF; #1;
      chk1("rr/busy", mmu_busy, 1'b0);
      chk1("rr/req_drop", dram_req, 1'b0);
      chkw("rr/odata", mmu_odata, 32'h0);
      step(); dram_rvalid = 1'b0; #1;
      chkw("rr/late_odata", mmu_odata, 32'h0);
      chk1("rr/late_busy", mmu_busy, 1'b0);
      chk1("rr/late_req", dram_req, 1'b0);

      // TLB hit path 0 -> 7 -> 7 -> 0: no traffic
      for (int i = 0; i < 4; i++) begin
         step(); pw_state = (i == 1 || i == 2) ? 3'd7 : 3'd0;
         pte_acs = 1'b1; pte_addr = 32'h8000_6000; #1;
         chk1("hit/busy", mmu_busy, 1'b0);
         chk1("hit/req", dram_req, 1'b0);
      end
      step(); #1;
      chk1("hit/end_req", dram_req, 1'b0);
      chkw("hit/odata", mmu_odata, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
